// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART serial engine.
// Frame layout is 8N1: start, 8 data bits LSB first, stop.
package uart_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SEND,
    TX_DUMMY
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam int          FRAME_BITS    = 10;
  localparam int          MIN_DIV       = 4;
  localparam logic [31:0] RX_EMPTY_DATA = 32'hFFFF_FFFF;

  function automatic logic [31:0] eff_period(input logic [31:0] div);
    return (div < 32'(MIN_DIV)) ? 32'(MIN_DIV) : div;
  endfunction

endpackage

// File: rtl/uart_if.sv
// uart_if: register-strobe bus between the AXI4-lite adapter and the core.
// master = adapter side, slave = uart_core side.
interface uart_if;
  logic [3:0]  reg_div_we;
  logic [31:0] reg_div_di;
  logic [31:0] reg_div_do;
  logic        reg_dat_we;
  logic        reg_dat_re;
  logic [31:0] reg_dat_di;
  logic [31:0] reg_dat_do;
  logic        reg_dat_wait;

  modport master (
    output reg_div_we, reg_div_di,
    output reg_dat_we, reg_dat_re, reg_dat_di,
    input  reg_div_do, reg_dat_do, reg_dat_wait
  );

  modport slave (
    input  reg_div_we, reg_div_di,
    input  reg_dat_we, reg_dat_re, reg_dat_di,
    output reg_div_do, reg_dat_do, reg_dat_wait
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: byte FIFO for received data, head always visible on dout.
// Push into a full FIFO is dropped unless a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign empty  = (r_cnt == '0);
  assign full   = (r_cnt == (AW+1)'(DEPTH));
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || pop);
  assign dout   = r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= din;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/uart_core.sv
// uart_core: 8N1 transmitter, receiver and RX FIFO behind the register bus.
// A divider write always restarts TX with a full idle frame at the new rate.
module uart_core
  import uart_pkg::*;
#(
  parameter int DEFAULT_DIV = 1,
  parameter int RX_DEPTH    = 4
) (
  input  logic   clk,
  input  logic   resetn,
  output logic   ser_tx,
  input  logic   ser_rx,
  uart_if.slave  bus
);

  logic [31:0] r_div;
  logic [31:0] w_per;
  logic [31:0] w_half;
  logic        w_div_wr;
  logic        w_unused;

  tx_state_t   r_tx_state, w_tx_state;
  logic [31:0] r_tx_cnt, w_tx_cnt;
  logic [3:0]  r_tx_bit, w_tx_bit;
  logic [9:0]  r_tx_shift, w_tx_shift;
  logic        w_tx_tick;

  logic        r_rx_s1, r_rx_s2;
  rx_state_t   r_rx_state, w_rx_state;
  logic [31:0] r_rx_cnt, w_rx_cnt;
  logic [2:0]  r_rx_bit, w_rx_bit;
  logic [7:0]  r_rx_shift, w_rx_shift;
  logic        w_rx_tick;
  logic        w_push;
  logic        w_empty;
  logic        w_unused_full;
  logic [7:0]  w_head;

  assign w_per    = eff_period(r_div);
  assign w_half   = w_per >> 1;
  assign w_div_wr = |bus.reg_div_we;
  assign w_unused = ^bus.reg_dat_di[31:8];

  // A data write lost to a same-cycle divider write must stall too.
  assign bus.reg_dat_wait = bus.reg_dat_we &&
                            ((r_tx_state != TX_IDLE) || w_div_wr);
  assign bus.reg_div_do   = r_div;
  assign bus.reg_dat_do   = w_empty ? RX_EMPTY_DATA : {24'h0, w_head};
  assign ser_tx = (r_tx_state == TX_SEND) ? r_tx_shift[0] : 1'b1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_div <= 32'(DEFAULT_DIV);
    end else begin
      for (int i = 0; i < 4; i++)
        if (bus.reg_div_we[i])
          r_div[8*i +: 8] <= bus.reg_div_di[8*i +: 8];
    end
  end

  assign w_tx_tick = (r_tx_cnt == w_per - 32'd1);

  always_comb begin
    w_tx_state = r_tx_state;
    w_tx_cnt   = r_tx_cnt;
    w_tx_bit   = r_tx_bit;
    w_tx_shift = r_tx_shift;
    if (w_div_wr) begin
      w_tx_state = TX_DUMMY;
      w_tx_cnt   = '0;
      w_tx_bit   = '0;
    end else begin
      unique case (r_tx_state)
        TX_IDLE: begin
          if (bus.reg_dat_we) begin
            w_tx_state = TX_SEND;
            w_tx_shift = {1'b1, bus.reg_dat_di[7:0], 1'b0};
            w_tx_cnt   = '0;
            w_tx_bit   = '0;
          end
        end
        TX_SEND, TX_DUMMY: begin
          if (w_tx_tick) begin
            w_tx_cnt   = '0;
            w_tx_shift = {1'b1, r_tx_shift[9:1]};
            w_tx_bit   = r_tx_bit + 4'd1;
            if (r_tx_bit == 4'(FRAME_BITS - 1)) begin
              w_tx_state = TX_IDLE;
              w_tx_bit   = '0;
            end
          end else begin
            w_tx_cnt = r_tx_cnt + 32'd1;
          end
        end
        default: w_tx_state = TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tx_state <= TX_DUMMY;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '1;
    end else begin
      r_tx_state <= w_tx_state;
      r_tx_cnt   <= w_tx_cnt;
      r_tx_bit   <= w_tx_bit;
      r_tx_shift <= w_tx_shift;
    end
  end

  assign w_rx_tick = (r_rx_cnt ==
    ((r_rx_state == RX_START) ? w_half : w_per) - 32'd1);

  always_comb begin
    w_rx_state = r_rx_state;
    w_rx_cnt   = r_rx_cnt + 32'd1;
    w_rx_bit   = r_rx_bit;
    w_rx_shift = r_rx_shift;
    w_push     = 1'b0;
    unique case (r_rx_state)
      RX_IDLE: begin
        w_rx_cnt = '0;
        if (!r_rx_s2) w_rx_state = RX_START;
      end
      RX_START: begin
        if (w_rx_tick) begin
          w_rx_cnt   = '0;
          w_rx_bit   = '0;
          w_rx_state = r_rx_s2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (w_rx_tick) begin
          w_rx_cnt   = '0;
          w_rx_shift = {r_rx_s2, r_rx_shift[7:1]};
          w_rx_bit   = r_rx_bit + 3'd1;
          if (r_rx_bit == 3'd7) w_rx_state = RX_STOP;
        end
      end
      RX_STOP: begin
        if (w_rx_tick) begin
          w_rx_cnt   = '0;
          w_push     = r_rx_s2;
          w_rx_state = RX_IDLE;
        end
      end
      default: w_rx_state = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_s1    <= ser_rx;
      r_rx_s2    <= r_rx_s1;
      r_rx_state <= w_rx_state;
      r_rx_cnt   <= w_rx_cnt;
      r_rx_bit   <= w_rx_bit;
      r_rx_shift <= w_rx_shift;
    end
  end

  uart_rx_fifo #(.DEPTH(RX_DEPTH)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (w_push),
    .pop    (bus.reg_dat_re),
    .din    (r_rx_shift),
    .dout   (w_head),
    .empty  (w_empty),
    .full   (w_unused_full)
  );

endmodule
